input_stream_feeder: RTL and testbench

Input-side feeder between the input buffer and the systolic array in the DeiT core. It is driven by the global controller's `ctrl_input_stream_en` and `ctrl_drain_en`. While streaming, it issues one input-buffer read per cycle and turns each returned ARRAY_ROWS-lane vector into the diagonally skewed lane stream the array expects. During drain it pushes zeros so the array pipeline empties cleanly.

---
 rtl/input_stream_feeder.sv | 125 ++++++++++++
 tb/tb_input_stream_feeder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/input_stream_feeder.sv
// Input-buffer to systolic-array feeder: one buffer read per streaming cycle, optional per-lane skew.
// Build option FEEDER_SKEW_EN: when defined, lane r is delayed by r extra registers; otherwise all lanes present together.

`ifdef FEEDER_SKEW_EN
module feeder_skew_lane #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);
    logic [DEPTH-1:0]             r_vld_pipe;
    logic [DEPTH-1:0][DATA_W-1:0] r_dat_pipe;

    // Data is stored pre-masked so stale buffer contents never enter the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_dat_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= i_valid;
            r_dat_pipe[0] <= i_valid ? i_data : '0;
            for (int k = 1; k < DEPTH; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                r_dat_pipe[k] <= r_dat_pipe[k-1];
            end
        end
    end

    assign o_valid = r_vld_pipe[DEPTH-1];
    assign o_data  = o_valid ? r_dat_pipe[DEPTH-1] : '0;
endmodule
`endif

module input_stream_feeder #(
    parameter int ARRAY_ROWS = 12,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ctrl_input_stream_en,
    input  logic                         ctrl_drain_en,
    input  logic [ADDR_W-1:0]            cfg_base_addr,
    output logic                         buf_rd_en,
    output logic [ADDR_W-1:0]            buf_rd_addr,
    input  logic [ARRAY_ROWS*DATA_W-1:0] buf_rd_data,
    output logic [ARRAY_ROWS*DATA_W-1:0] arr_data,
    output logic [ARRAY_ROWS-1:0]        arr_valid,
    output logic [31:0]                  feed_count,
    output logic                         addr_wrap,
    output logic                         err_protocol
);
    logic              r_prev_en;
    logic              r_rd_valid;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [31:0]       r_feed_count;
    logic              r_addr_wrap;
    logic              r_err_protocol;

    logic              w_start;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_start   = ctrl_input_stream_en & ~r_prev_en;
    assign w_rd_addr = w_start ? cfg_base_addr : r_rd_ptr;

    assign buf_rd_en   = ctrl_input_stream_en;
    assign buf_rd_addr = w_rd_addr;

    // A non-start issue at pointer 0 can only follow an issue of the top address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_en      <= 1'b0;
            r_rd_valid     <= 1'b0;
            r_rd_ptr       <= '0;
            r_feed_count   <= '0;
            r_addr_wrap    <= 1'b0;
            r_err_protocol <= 1'b0;
        end else begin
            r_prev_en  <= ctrl_input_stream_en;
            r_rd_valid <= ctrl_input_stream_en;
            if (ctrl_input_stream_en)
                r_rd_ptr <= w_rd_addr + 1'b1;
            if (w_start)
                r_feed_count <= 32'd1;
            else if (ctrl_input_stream_en && r_feed_count != '1)
                r_feed_count <= r_feed_count + 32'd1;
            if (w_start)
                r_addr_wrap <= 1'b0;
            else if (ctrl_input_stream_en && r_rd_ptr == '0)
                r_addr_wrap <= 1'b1;
            r_err_protocol <= (r_err_protocol & ~w_start) |
                              (ctrl_input_stream_en & ctrl_drain_en);
        end
    end

    assign feed_count   = r_feed_count;
    assign addr_wrap    = r_addr_wrap;
    assign err_protocol = r_err_protocol;

    for (genvar r = 0; r < ARRAY_ROWS; r++) begin : g_lane
`ifdef FEEDER_SKEW_EN
        if (r == 0) begin : g_head
            assign arr_valid[0]          = r_rd_valid;
            assign arr_data[0 +: DATA_W] = r_rd_valid ? buf_rd_data[0 +: DATA_W] : '0;
        end else begin : g_skew
            feeder_skew_lane #(.DEPTH(r), .DATA_W(DATA_W)) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_data  (buf_rd_data[r*DATA_W +: DATA_W]),
                .i_valid (r_rd_valid),
                .o_data  (arr_data[r*DATA_W +: DATA_W]),
                .o_valid (arr_valid[r])
            );
        end
`else
        assign arr_valid[r]               = r_rd_valid;
        assign arr_data[r*DATA_W +: DATA_W] = r_rd_valid ? buf_rd_data[r*DATA_W +: DATA_W] : '0;
`endif
    end
endmodule

// File: tb/tb_input_stream_feeder.sv
// Randomized self-checking bench for input_stream_feeder against a job-level reference model.
module tb_input_stream_feeder;
    localparam int ROWS = 12;
    localparam int DW   = 8;
    localparam int AW   = 10;
    localparam int VW   = ROWS*DW;
`ifdef FEEDER_SKEW_EN
    localparam int SKEW = 1;
`else
    localparam int SKEW = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stream_en = 1'b0, drain_en = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          buf_rd_en;
    logic [AW-1:0] buf_rd_addr;
    logic [VW-1:0] buf_rd_data = '0;
    logic [VW-1:0] arr_data;
    logic [ROWS-1:0] arr_valid;
    logic [31:0]   feed_count;
    logic          addr_wrap, err_protocol;

    input_stream_feeder #(.ARRAY_ROWS(ROWS), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ctrl_input_stream_en(stream_en), .ctrl_drain_en(drain_en),
        .cfg_base_addr(base_addr),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
        .arr_data(arr_data), .arr_valid(arr_valid),
        .feed_count(feed_count), .addr_wrap(addr_wrap), .err_protocol(err_protocol)
    );

    always #5 clk = ~clk;

    // Buffer model: 1-cycle read latency, junk on the bus when not reading.
    logic [VW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
        else           buf_rd_data <= {$urandom, $urandom, $urandom};
    end

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    bit            iss    [0:4095];
    logic [VW-1:0] issdat [0:4095];
    bit            m_prev_en = 1'b0;
    logic [AW-1:0] m_base = '0;
    int            m_n = 0;
    bit            m_err = 1'b0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic check_zero_outputs();
        chk("rst_rd_en", 128'(buf_rd_en), 128'(0));
        chk("rst_rd_addr", 128'(buf_rd_addr), 128'(0));
        chk("rst_arr_valid", 128'(arr_valid), 128'(0));
        chk("rst_arr_data", 128'(arr_data), 128'(0));
        chk("rst_feed_count", 128'(feed_count), 128'(0));
        chk("rst_wrap", 128'(addr_wrap), 128'(0));
        chk("rst_err", 128'(err_protocol), 128'(0));
    endtask

    // Lane r shows the vector issued 1 + SKEW*r cycles earlier, else zero.
    task automatic check_outputs();
        logic [ROWS-1:0] ev;
        logic [VW-1:0]   ed;
        ev = '0;
        ed = '0;
        for (int r = 0; r < ROWS; r++) begin
            int s;
            s = cyc - 1 - SKEW*r;
            if (s >= 0 && iss[s]) begin
                ev[r] = 1'b1;
                ed[r*DW +: DW] = issdat[s][r*DW +: DW];
            end
        end
        chk("arr_valid", 128'(arr_valid), 128'(ev));
        chk("arr_data", 128'(arr_data), 128'(ed));
        chk("feed_count", 128'(feed_count), 128'(m_n));
        chk("addr_wrap", 128'(addr_wrap), 128'((int'(m_base) + m_n) > (1 << AW)));
        chk("err_protocol", 128'(err_protocol), 128'(m_err));
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic tick(input bit en, input bit dr, input logic [AW-1:0] base);
        logic [AW-1:0] a;
        stream_en = en;
        drain_en  = dr;
        base_addr = base;
        #1;
        if (en && !m_prev_en) begin
            m_base = base;
            m_n    = 0;
            m_err  = 1'b0;
        end
        a = m_base + m_n[AW-1:0];
        chk("rd_en", 128'(buf_rd_en), 128'(en));
        if (en) chk("rd_addr", 128'(buf_rd_addr), 128'(a));
        iss[cyc]    = en;
        issdat[cyc] = mem[a];
        if (en) m_n++;
        if (en && dr) m_err = 1'b1;
        m_prev_en = en;
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit dr);
        for (int i = 0; i < n; i++) tick(1'b0, dr, AW'($urandom));
    endtask

    task automatic job(input logic [AW-1:0] base, input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, (i == 0) ? base : AW'($urandom));
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom, $urandom};
        #3;
        check_zero_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // basic stream, then let every lane empty
        job(10'h010, 4);
        idle(ROWS + 2, 1'b1);
        // address wrap
        job(10'h3FE, 4);
        idle(3, 1'b0);
        // drain zeros after a job of constant 0x7F vectors
        for (int i = 0; i < 6; i++) mem[10'h100 + i] = {ROWS{8'h7F}};
        job(10'h100, 6);
        idle(ROWS + 2, 1'b1);
        // protocol error in the middle of a job; sticks until next start
        tick(1'b1, 1'b0, 10'h050);
        tick(1'b1, 1'b1, 10'h000);
        tick(1'b1, 1'b0, 10'h000);
        idle(4, 1'b0);
        job(10'h060, 2);
        idle(2, 1'b0);
        // single-cycle pulses, one-cycle gaps
        tick(1'b1, 1'b0, 10'h3FF);
        idle(1, 1'b0);
        tick(1'b1, 1'b0, 10'h200);
        idle(ROWS + 1, 1'b0);

        // reset at the 3rd issue cycle of an 8-cycle job
        job(10'h0A0, 2);
        stream_en = 1'b0;
        drain_en  = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_zero_outputs();
        for (int i = 0; i <= cyc; i++) iss[i] = 1'b0;
        m_prev_en = 1'b0;
        m_base    = '0;
        m_n       = 0;
        m_err     = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        check_zero_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        job(10'h020, 5);
        idle(ROWS + 1, 1'b0);

        // random traffic
        for (int i = 0; i < 500; i++)
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, AW'($urandom));
        idle(ROWS + 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
